// File: rtl/imm_pkg.sv
// Shared types and constants for the RV32 immediate generator pipeline.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package imm_pkg;

  // Immediate format codes presented on out_fmt
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } fmt_e;

  // Major opcodes (instr[6:0]) recognised by the decoder
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // Skid buffer occupancy: 0, 1 or 2 entries held
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/imm_extract.sv
// Combinational RV32 format decode and sign-extended immediate build.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows instr directly.
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  fmt_e w_fmt;

  // Classify the opcode; anything not listed (incl. instr[1:0] != 2'b11) is illegal
  always_comb begin
    w_fmt   = FMT_NONE;
    illegal = 1'b0;
    case (instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR: w_fmt = FMT_I;
      OP_STORE:                 w_fmt = FMT_S;
      OP_BRANCH:                w_fmt = FMT_B;
      OP_LUI, OP_AUIPC:         w_fmt = FMT_U;
      OP_JAL:                   w_fmt = FMT_J;
      OP_REG:                   w_fmt = FMT_NONE;
      default:                  illegal = 1'b1;
    endcase
  end

  // Scatter the immediate fields and sign-extend from instr[31] to XLEN
  always_comb begin
    imm = '0;
    case (w_fmt)
      FMT_I: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      FMT_S: imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U: imm = {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0};
      FMT_J: imm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  assign fmt = w_fmt;

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator behind a 2-entry (main + skid) buffer.
// Latency: 1 cycle from input accept to out_valid; 1 instr/cycle when out_ready=1.
// Backpressure: in_ready is a register, low only when both entries are held.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int PASS_INSTR = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [31:0]     out_instr,
  output logic [15:0]     illegal_cnt
);

  logic [XLEN-1:0] w_imm;
  logic [2:0]      w_fmt;
  logic            w_ill;

  state_e          r_state;
  state_e          w_state_nxt;
  logic            r_in_rdy;

  logic [XLEN-1:0] r_m_imm;
  logic [2:0]      r_m_fmt;
  logic            r_m_ill;
  logic [31:0]     r_m_instr;

  logic [XLEN-1:0] r_s_imm;
  logic [2:0]      r_s_fmt;
  logic            r_s_ill;
  logic [31:0]     r_s_instr;

  logic [15:0]     r_cnt;

  logic            w_acc;
  logic            w_drn;
  logic            w_ld_main_in;
  logic            w_ld_main_skid;
  logic            w_ld_skid;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr   (in_instr),
    .imm     (w_imm),
    .fmt     (w_fmt),
    .illegal (w_ill)
  );

  // A flushed cycle never accepts, so flushed inputs cannot reach the counter
  assign w_acc     = in_valid & r_in_rdy & ~flush;
  assign w_drn     = (r_state != ST_EMPTY) & out_ready;
  assign out_valid = (r_state != ST_EMPTY);
  assign in_ready  = r_in_rdy;

  // Next occupancy and which register loads from where
  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            w_state_nxt  = ST_ONE;
            w_ld_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_acc && w_drn) begin
            w_ld_main_in = 1'b1;
          end else if (w_acc) begin
            w_state_nxt = ST_FULL;
            w_ld_skid   = 1'b1;
          end else if (w_drn) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // The skid entry is always the younger one, so it moves up on drain
          if (w_drn) begin
            w_state_nxt    = ST_ONE;
            w_ld_main_skid = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Occupancy register and the registered in_ready derived from next occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_EMPTY;
      r_in_rdy <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_in_rdy <= (w_state_nxt != ST_FULL);
    end
  end

  // Main entry: loads fresh decode results or is refilled from the skid entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_imm   <= '0;
      r_m_fmt   <= FMT_NONE;
      r_m_ill   <= 1'b0;
      r_m_instr <= '0;
    end else if (w_ld_main_in) begin
      r_m_imm   <= w_imm;
      r_m_fmt   <= w_fmt;
      r_m_ill   <= w_ill;
      r_m_instr <= in_instr;
    end else if (w_ld_main_skid) begin
      r_m_imm   <= r_s_imm;
      r_m_fmt   <= r_s_fmt;
      r_m_ill   <= r_s_ill;
      r_m_instr <= r_s_instr;
    end
  end

  // Skid entry: catches the one instruction accepted while main is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_imm   <= '0;
      r_s_fmt   <= FMT_NONE;
      r_s_ill   <= 1'b0;
      r_s_instr <= '0;
    end else if (w_ld_skid) begin
      r_s_imm   <= w_imm;
      r_s_fmt   <= w_fmt;
      r_s_ill   <= w_ill;
      r_s_instr <= in_instr;
    end
  end

  // Saturating count of accepted illegal instructions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_acc && w_ill && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign out_imm     = r_m_imm;
  assign out_fmt     = r_m_fmt;
  assign out_illegal = r_m_ill;
  assign out_instr   = (PASS_INSTR != 0) ? r_m_instr : 32'd0;
  assign illegal_cnt = r_cnt;

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the immediate output width; the legal values are 32 and 64.
REQ-002 SHALL have parameter PASS_INSTR, default 1, meaning: when 1, the instruction is forwarded on out_instr; when 0, out_instr is tied to 0.
REQ-003 SHALL have port clk, input, 1, the single clock; all state is rising-edge.
REQ-004 SHALL have port rst_n, input, 1, the reset: asynchronous assert, active-low.
REQ-005 SHALL have port flush, input, 1, a synchronous discard of all buffered entries.
REQ-006 SHALL have port in_valid, input, 1, meaning the upstream instruction is valid.
REQ-007 SHALL have port in_ready, output, 1, meaning the block accepts input this cycle.
REQ-008 SHALL have port in_instr, input, 32, the raw RV32 instruction word.
REQ-009 SHALL have port out_valid, output, 1, meaning the result is valid.
REQ-010 SHALL have port out_ready, input, 1, meaning downstream accepts the result.
REQ-011 SHALL have port out_imm, output, XLEN, the sign-extended immediate.
REQ-012 SHALL have port out_fmt, output, 3, the format code: NONE=0, I=1, S=2, B=3, U=4, J=5.
REQ-013 SHALL have port out_illegal, output, 1, meaning the opcode is unsupported or instr[1:0] is not 2'b11.
REQ-014 SHALL have port out_instr, output, 32, the forwarded instruction.
REQ-015 SHALL have port illegal_cnt, output, 16, a saturating count of accepted illegal instructions.

Function
REQ-016 SHALL decode the format from instr[6:0] as follows:
- 0010011, 0000011, 1100111 -> I
- 0100011 -> S
- 1100011 -> B
- 0110111, 0010111 -> U
- 1101111 -> J
- 0110011 -> NONE, with illegal=0
- any other value -> NONE, with illegal=1
REQ-017 SHALL build the immediate as follows, with every format sign-extended from instr[31] to XLEN:
- I: instr[31:20]
- S: {instr[31:25], instr[11:7]}
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
- U: {instr[31:12], 12'b0}
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
- NONE: 0
REQ-018 SHALL register its results with exactly 1 cycle latency: an instruction accepted at edge N is presented with out_valid=1 after edge N.
REQ-019 SHALL treat a transfer as occurring only on a cycle where valid and ready are both 1, on each side independently.
REQ-020 SHALL hold out_imm, out_fmt, out_illegal and out_instr stable while out_valid=1 and out_ready=0.
REQ-021 SHALL implement a 2-entry skid buffer (main + skid) so that in_ready is driven directly from a register, never combinationally from out_ready.
REQ-022 SHALL sustain a throughput of 1 instruction per cycle while out_ready is held at 1.
REQ-023 SHALL use three states: EMPTY, ONE and FULL (0, 1 and 2 entries held).
REQ-024 SHALL set in_ready=1 in EMPTY and ONE, and in_ready=0 in FULL.
REQ-025 SHALL make the following state transitions:
- EMPTY with an accept -> ONE
- ONE with an accept and no drain -> FULL
- ONE with a drain and no accept -> EMPTY
- ONE with both an accept and a drain -> ONE
- FULL with a drain -> ONE, with the skid entry moving into main
REQ-026 SHALL preserve order: the skid entry is always younger than the main entry.
REQ-027 SHALL, on flush, go to EMPTY with out_valid=0 on the next cycle, discarding any same-cycle in_valid; illegal_cnt is not altered by flushed entries.
REQ-028 SHALL increment illegal_cnt when an illegal instruction is accepted, saturating at 16'hFFFF with no wrap-around; an accept coinciding with flush is not counted.

Reset
REQ-029 SHALL, while rst_n=0, force the state to EMPTY, out_valid=0, in_ready=0, out_imm=0, out_fmt=NONE, out_illegal=0, out_instr=0 and illegal_cnt=0, asynchronously.
REQ-030 SHALL drive in_ready=1 from the first clock edge after rst_n deasserts.
REQ-031 SHALL, when reset asserts mid-transfer, drop all buffered entries with no partial output.

Structure
REQ-032 SHALL place the format enum, opcode constants and the FMT_* codes in a shared package imm_pkg.
REQ-033 SHALL contain one combinational sub-module, imm_extract, parameterised by XLEN (inputs instr; outputs imm, fmt, illegal), instantiated once on the input side.

Verification
REQ-034 SHALL cover this scenario with XLEN=32 and out_ready=1, feeding each instruction back-to-back:
- f9c30293 -> imm FFFFFF9C, fmt I
- 0c832283 -> imm 000000C8, fmt I
- 02528063 -> imm 00000020, fmt B
- 008002ef -> imm 00000008, fmt J
- 100302e7 -> imm 00000100, fmt I
- 800ff337 -> imm 800FF000, fmt U
- each result arrives 1 cycle after its input, with no gaps.
REQ-035 SHALL cover, with XLEN=64, input 800ff337 -> out_imm FFFFFFFF800FF000, fmt U.
REQ-036 SHALL cover backpressure: out_ready=0 while 3 instructions are offered -> exactly 2 accepted, in_ready=0 after the second; then out_ready=1 -> outputs appear in order and in_ready returns 1.
REQ-037 SHALL cover illegal inputs: 00000000 and 0000007F -> out_illegal=1, fmt NONE, illegal_cnt=2; 00c58533 (R-type) -> illegal=0, imm 0.
REQ-038 SHALL cover flush while FULL with in_valid=1 -> out_valid=0 next cycle, state EMPTY, and no output from the flushed entries.
REQ-039 SHALL cover rst_n asserted mid-stream -> all outputs 0 immediately; after release, the first accepted instruction emerges correctly 1 cycle later.
